// File: rtl/io_mux_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : io_mux_ctrl_if
// Brief    : Wishbone slave bus bundle for the pad multiplexer controller.
// Revision : 1.0 - initial release
// ============================================================================
interface io_mux_ctrl_if;
    logic        wbs_cyc_i;
    logic        wbs_stb_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic [31:0] wbs_dat_o;
    logic        wbs_ack_o;

    modport master (
        output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_dat_o, wbs_ack_o
    );

    modport slave (
        input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_dat_o, wbs_ack_o
    );
endinterface
`default_nettype wire

// File: rtl/io_mux_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : io_mux_ctrl
// Brief    : Wishbone-programmed pad multiplexer selecting one of NUM_DESIGNS
//            user designs, with tristate + reset-hold safe switchover.
// Revision : 1.0 - initial release
// ============================================================================
module io_mux_ctrl #(
    parameter int          NUM_DESIGNS = 4,
    parameter int          IO_WIDTH    = 38,
    parameter int          RST_HOLD    = 16,
    parameter logic [31:0] BASE_ADDR   = 32'h3000_0000
) (
    input  wire logic                            wb_clk_i,
    input  wire logic                            wb_rst_i,
    io_mux_ctrl_if.slave                         wb,
    input  wire logic                            io_in_0,
    input  wire logic [NUM_DESIGNS*IO_WIDTH-1:0] dsn_io_out,
    input  wire logic [NUM_DESIGNS*IO_WIDTH-1:0] dsn_io_oeb,
    output logic      [NUM_DESIGNS-1:0]          dsn_rst_n,
    output logic      [IO_WIDTH-1:0]             io_out,
    output logic      [IO_WIDTH-1:0]             io_oeb,
    output logic      [31:0]                     custom_settings,
    output logic      [7:0]                      status
);

    localparam int                c_CW        = $clog2(RST_HOLD);
    localparam logic [c_CW-1:0]   c_HOLD_LOAD = c_CW'(RST_HOLD - 1);
    localparam logic [4:0]        c_NUM       = 5'(NUM_DESIGNS);

    typedef enum logic [1:0] {
        ST_ACTIVE  = 2'd0,
        ST_QUIESCE = 2'd1,
        ST_HOLD    = 2'd2
    } state_t;

    state_t              state_q,    state_d;
    logic [c_CW-1:0]     cnt_q,      cnt_d;
    logic [3:0]          cur_sel_q,  cur_sel_d;
    logic [3:0]          target_q,   target_d;
    logic                fault_q,    fault_d;
    logic [31:0]         settings_q, settings_d;
    logic                ack_q,      ack_d;
    logic [31:0]         dat_q,      dat_d;
    logic                meta_q,     meta_d;
    logic                rst_sync_q, rst_sync_d;
    logic [IO_WIDTH-1:0] io_out_q,   io_out_d;
    logic [IO_WIDTH-1:0] io_oeb_q,   io_oeb_d;

    logic       w_hit;
    logic       w_req;
    logic [1:0] w_reg;
    logic       w_sel_wr;
    logic       w_sel_valid;
    logic       w_sel_bad;
    logic       w_unused;

    assign w_hit       = wb.wbs_cyc_i & wb.wbs_stb_i
                       & (wb.wbs_adr_i[31:4] == BASE_ADDR[31:4]);
    // A held request is acked once; the following cycle it is a fresh access.
    assign w_req       = w_hit & ~ack_q;
    assign w_reg       = wb.wbs_adr_i[3:2];
    assign w_sel_wr    = w_req & wb.wbs_we_i & (w_reg == 2'd0) & wb.wbs_sel_i[0];
    assign w_sel_valid = w_sel_wr & ({1'b0, wb.wbs_dat_i[3:0]} < c_NUM);
    assign w_sel_bad   = w_sel_wr & ~w_sel_valid;
    assign w_unused    = ^wb.wbs_adr_i[1:0];

    assign status = {fault_q, state_q, 1'b0, cur_sel_q};

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        cur_sel_d  = cur_sel_q;
        target_d   = target_q;
        fault_d    = fault_q;
        settings_d = settings_q;
        ack_d      = w_req;
        dat_d      = 32'd0;
        meta_d     = io_in_0;
        rst_sync_d = meta_q;
        io_out_d   = '0;
        io_oeb_d   = '1;

        if (w_req && !wb.wbs_we_i) begin
            case (w_reg)
                2'd0:    dat_d = {28'd0, target_q};
                2'd1:    dat_d = settings_q;
                2'd2:    dat_d = {24'd0, status};
                default: dat_d = 32'd0;
            endcase
        end

        if (w_req && wb.wbs_we_i && (w_reg == 2'd1)) begin
            for (int b = 0; b < 4; b++) begin
                if (wb.wbs_sel_i[b]) settings_d[8*b +: 8] = wb.wbs_dat_i[8*b +: 8];
            end
        end

        if (w_sel_valid)    fault_d = 1'b0;
        else if (w_sel_bad) fault_d = 1'b1;

        case (state_q)
            ST_ACTIVE: begin
                if (w_sel_valid && (wb.wbs_dat_i[3:0] != cur_sel_q)) begin
                    target_d = wb.wbs_dat_i[3:0];
                    state_d  = ST_QUIESCE;
                end
            end
            ST_QUIESCE: begin
                state_d = ST_HOLD;
                cnt_d   = c_HOLD_LOAD;
                if (w_sel_valid) target_d = wb.wbs_dat_i[3:0];
            end
            ST_HOLD: begin
                if (w_sel_valid) begin
                    target_d = wb.wbs_dat_i[3:0];
                    cnt_d    = c_HOLD_LOAD;
                end else if (cnt_q == '0) begin
                    cur_sel_d = target_q;
                    state_d   = ST_ACTIVE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = ST_HOLD;
                cnt_d   = c_HOLD_LOAD;
            end
        endcase

        // Pads see the selected design one cycle late; outside ACTIVE they are tristated.
        if (state_q == ST_ACTIVE) begin
            for (int d = 0; d < NUM_DESIGNS; d++) begin
                if (4'(d) == cur_sel_q) begin
                    io_out_d = dsn_io_out[d*IO_WIDTH +: IO_WIDTH];
                    io_oeb_d = dsn_io_oeb[d*IO_WIDTH +: IO_WIDTH];
                end
            end
        end
    end

    always_comb begin
        dsn_rst_n = '0;
        if (state_q == ST_ACTIVE) begin
            for (int d = 0; d < NUM_DESIGNS; d++) begin
                if (4'(d) == cur_sel_q) dsn_rst_n[d] = ~rst_sync_q;
            end
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q    <= ST_HOLD;
            cnt_q      <= c_HOLD_LOAD;
            cur_sel_q  <= 4'd0;
            target_q   <= 4'd0;
            fault_q    <= 1'b0;
            settings_q <= 32'd0;
            ack_q      <= 1'b0;
            dat_q      <= 32'd0;
            meta_q     <= 1'b0;
            rst_sync_q <= 1'b0;
            io_out_q   <= '0;
            io_oeb_q   <= '1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cur_sel_q  <= cur_sel_d;
            target_q   <= target_d;
            fault_q    <= fault_d;
            settings_q <= settings_d;
            ack_q      <= ack_d;
            dat_q      <= dat_d;
            meta_q     <= meta_d;
            rst_sync_q <= rst_sync_d;
            io_out_q   <= io_out_d;
            io_oeb_q   <= io_oeb_d;
        end
    end

    assign wb.wbs_ack_o    = ack_q;
    assign wb.wbs_dat_o    = dat_q;
    assign io_out          = io_out_q;
    assign io_oeb          = io_oeb_q;
    assign custom_settings = settings_q;

endmodule
`default_nettype wire

// File: tb/tb_io_mux_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_io_mux_ctrl
// Brief    : Directed self-checking bench for io_mux_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_io_mux_ctrl;
    localparam int          c_ND   = 4;
    localparam int          c_IOW  = 38;
    localparam logic [31:0] c_BASE = 32'h3000_0000;

    logic                  wb_clk_i;
    logic                  wb_rst_i;
    logic                  io_in_0;
    logic [c_ND*c_IOW-1:0] dsn_io_out;
    logic [c_ND*c_IOW-1:0] dsn_io_oeb;
    logic [c_ND-1:0]       dsn_rst_n;
    logic [c_IOW-1:0]      io_out;
    logic [c_IOW-1:0]      io_oeb;
    logic [31:0]           custom_settings;
    logic [7:0]            status;

    int n_checks = 0;
    int n_errors = 0;

    io_mux_ctrl_if wb_if ();

    io_mux_ctrl #(
        .NUM_DESIGNS (c_ND),
        .IO_WIDTH    (c_IOW),
        .RST_HOLD    (16),
        .BASE_ADDR   (c_BASE)
    ) u_dut (
        .wb_clk_i        (wb_clk_i),
        .wb_rst_i        (wb_rst_i),
        .wb              (wb_if),
        .io_in_0         (io_in_0),
        .dsn_io_out      (dsn_io_out),
        .dsn_io_oeb      (dsn_io_oeb),
        .dsn_rst_n       (dsn_rst_n),
        .io_out          (io_out),
        .io_oeb          (io_oeb),
        .custom_settings (custom_settings),
        .status          (status)
    );

    initial wb_clk_i = 1'b0;
    always #5 wb_clk_i = ~wb_clk_i;

    function automatic logic [c_IOW-1:0] pat_out(input int d);
        return 38'h2A_0F0F_0F00 | 38'(d + 1);
    endfunction

    function automatic logic [c_IOW-1:0] pat_oeb(input int d);
        return 38'(d * 3);
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge wb_clk_i);
        #1;
    endtask

    task automatic wb_write(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
        if (wb_if.wbs_ack_o) tick();
        wb_if.wbs_cyc_i = 1'b1;
        wb_if.wbs_stb_i = 1'b1;
        wb_if.wbs_we_i  = 1'b1;
        wb_if.wbs_adr_i = adr;
        wb_if.wbs_dat_i = dat;
        wb_if.wbs_sel_i = sel;
        tick();
        check_eq("wr_ack", 64'(wb_if.wbs_ack_o), 64'd1);
        wb_if.wbs_cyc_i = 1'b0;
        wb_if.wbs_stb_i = 1'b0;
        wb_if.wbs_we_i  = 1'b0;
    endtask

    task automatic wb_read(input logic [31:0] adr, output logic [31:0] dat, output logic ack);
        if (wb_if.wbs_ack_o) tick();
        wb_if.wbs_cyc_i = 1'b1;
        wb_if.wbs_stb_i = 1'b1;
        wb_if.wbs_we_i  = 1'b0;
        wb_if.wbs_adr_i = adr;
        wb_if.wbs_sel_i = 4'hF;
        tick();
        dat = wb_if.wbs_dat_o;
        ack = wb_if.wbs_ack_o;
        wb_if.wbs_cyc_i = 1'b0;
        wb_if.wbs_stb_i = 1'b0;
    endtask

    initial begin
        logic [31:0] rd;
        logic        ak;

        wb_rst_i        = 1'b1;
        io_in_0         = 1'b0;
        wb_if.wbs_cyc_i = 1'b0;
        wb_if.wbs_stb_i = 1'b0;
        wb_if.wbs_we_i  = 1'b0;
        wb_if.wbs_sel_i = 4'h0;
        wb_if.wbs_adr_i = 32'd0;
        wb_if.wbs_dat_i = 32'd0;
        for (int d = 0; d < c_ND; d++) begin
            dsn_io_out[d*c_IOW +: c_IOW] = pat_out(d);
            dsn_io_oeb[d*c_IOW +: c_IOW] = pat_oeb(d);
        end

        // Reset values
        tick();
        tick();
        check_eq("rst_oeb",    64'(io_oeb),          64'(38'h3F_FFFF_FFFF));
        check_eq("rst_out",    64'(io_out),          64'd0);
        check_eq("rst_rstn",   64'(dsn_rst_n),       64'd0);
        check_eq("rst_set",    64'(custom_settings), 64'd0);
        check_eq("rst_ack",    64'(wb_if.wbs_ack_o), 64'd0);
        check_eq("rst_dat",    64'(wb_if.wbs_dat_o), 64'd0);
        check_eq("rst_status", 64'(status),          64'h40);

        // Release: design 0 comes out of reset after 16 cycles
        wb_rst_i = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();
            check_eq("boot_rstn", 64'(dsn_rst_n), 64'd0);
            check_eq("boot_oeb",  64'(io_oeb),    64'(38'h3F_FFFF_FFFF));
        end
        tick();
        check_eq("boot_rel",  64'(dsn_rst_n), 64'b0001);
        check_eq("boot_oeb1", 64'(io_oeb),    64'(38'h3F_FFFF_FFFF));
        tick();
        check_eq("boot_out",  64'(io_out), 64'(pat_out(0)));
        check_eq("boot_oebd", 64'(io_oeb), 64'(pat_oeb(0)));
        check_eq("boot_stat", 64'(status), 64'h00);

        // Switch 0 -> 2: 17 cycles of quiesce+hold
        wb_write(c_BASE, 32'd2, 4'b0001);
        check_eq("sw2_q_rstn", 64'(dsn_rst_n), 64'd0);
        check_eq("sw2_q_stat", 64'(status),    64'h20);
        for (int i = 0; i < 16; i++) begin
            tick();
            check_eq("sw2_rstn", 64'(dsn_rst_n), 64'd0);
            check_eq("sw2_oeb",  64'(io_oeb),    64'(38'h3F_FFFF_FFFF));
        end
        tick();
        check_eq("sw2_rel",  64'(dsn_rst_n), 64'b0100);
        check_eq("sw2_stat", 64'(status),    64'h02);
        tick();
        check_eq("sw2_out",  64'(io_out), 64'(pat_out(2)));
        check_eq("sw2_oebd", 64'(io_oeb), 64'(pat_oeb(2)));

        // Retarget mid-hold: 1 then 3 eight cycles later
        wb_write(c_BASE, 32'd1, 4'b0001);
        for (int i = 0; i < 7; i++) tick();
        wb_write(c_BASE, 32'd3, 4'b0001);
        check_eq("rt_stat", 64'(status), 64'h42);
        for (int i = 0; i < 15; i++) begin
            tick();
            check_eq("rt_rstn", 64'(dsn_rst_n), 64'd0);
        end
        tick();
        check_eq("rt_rel",  64'(dsn_rst_n), 64'b1000);
        check_eq("rt_stat", 64'(status),    64'h03);

        // Out-of-range select sets fault, valid select clears it and switches
        wb_write(c_BASE, 32'd7, 4'b0001);
        check_eq("bad_stat", 64'(status),    64'h83);
        tick();
        check_eq("bad_rstn", 64'(dsn_rst_n), 64'b1000);
        check_eq("bad_stat2", 64'(status),   64'h83);
        wb_read(c_BASE, rd, ak);
        check_eq("bad_tgt",  64'(rd), 64'd3);
        wb_write(c_BASE, 32'd1, 4'b0001);
        check_eq("fix_stat", 64'(status), 64'h23);
        for (int i = 0; i < 17; i++) tick();
        check_eq("fix_rel",  64'(dsn_rst_n), 64'b0010);
        check_eq("fix_stat2", 64'(status),   64'h01);

        // Settings byte lanes, reads, ignored writes, address miss
        wb_write(c_BASE + 32'h4, 32'hA5A5_A5A5, 4'b0010);
        check_eq("set_bus", 64'(custom_settings), 64'h0000_A500);
        wb_read(c_BASE + 32'h4, rd, ak);
        check_eq("set_rd_ack", 64'(ak), 64'd1);
        check_eq("set_rd",     64'(rd), 64'h0000_A500);
        wb_read(c_BASE + 32'h8, rd, ak);
        check_eq("stat_rd", 64'(rd), 64'h01);
        wb_read(c_BASE + 32'hC, rd, ak);
        check_eq("rsv_ack", 64'(ak), 64'd1);
        check_eq("rsv_rd",  64'(rd), 64'd0);
        wb_read(c_BASE + 32'h10, rd, ak);
        check_eq("miss_ack", 64'(ak), 64'd0);
        check_eq("miss_dat", 64'(rd), 64'd0);
        wb_write(c_BASE + 32'h8, 32'hFF, 4'hF);
        check_eq("ro_stat", 64'(status), 64'h01);
        wb_write(c_BASE, 32'd3, 4'b1110);
        check_eq("lane_stat", 64'(status), 64'h01);
        tick();

        // Held request: ack for one cycle, gap, then a fresh ack
        wb_if.wbs_cyc_i = 1'b1;
        wb_if.wbs_stb_i = 1'b1;
        wb_if.wbs_we_i  = 1'b0;
        wb_if.wbs_adr_i = c_BASE + 32'h4;
        tick();
        check_eq("hold_ack1", 64'(wb_if.wbs_ack_o), 64'd1);
        tick();
        check_eq("hold_ack0", 64'(wb_if.wbs_ack_o), 64'd0);
        check_eq("hold_dat0", 64'(wb_if.wbs_dat_o), 64'd0);
        tick();
        check_eq("hold_ack2", 64'(wb_if.wbs_ack_o), 64'd1);
        wb_if.wbs_cyc_i = 1'b0;
        wb_if.wbs_stb_i = 1'b0;
        tick();

        // External reset pin through the 2-FF synchroniser
        io_in_0 = 1'b1;
        tick();
        check_eq("pin_sync1", 64'(dsn_rst_n), 64'b0010);
        for (int i = 0; i < 4; i++) begin
            tick();
            check_eq("pin_rstn", 64'(dsn_rst_n), 64'd0);
            check_eq("pin_out",  64'(io_out),    64'(pat_out(1)));
        end
        io_in_0 = 1'b0;
        tick();
        check_eq("pin_tail", 64'(dsn_rst_n), 64'd0);
        tick();
        check_eq("pin_back", 64'(dsn_rst_n), 64'b0010);
        check_eq("pin_stat", 64'(status),    64'h01);

        // Reset mid-switch restarts the boot sequence on design 0
        wb_write(c_BASE, 32'd2, 4'b0001);
        tick();
        tick();
        #2;
        wb_rst_i = 1'b1;
        #1;
        check_eq("mid_rstn", 64'(dsn_rst_n),       64'd0);
        check_eq("mid_stat", 64'(status),          64'h40);
        check_eq("mid_oeb",  64'(io_oeb),          64'(38'h3F_FFFF_FFFF));
        check_eq("mid_set",  64'(custom_settings), 64'd0);
        tick();
        wb_rst_i = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();
            check_eq("mid_hold", 64'(dsn_rst_n), 64'd0);
        end
        tick();
        check_eq("mid_rel", 64'(dsn_rst_n), 64'b0001);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
